// File: rtl/uart_byte_tx.sv
// Byte-wide UART transmitter (8N1, LSB first) fed by a rising-edge-captured strobe
// through a small circular FIFO; drops and flags bytes that arrive while the FIFO is full.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 2
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic [7:0]         din,
    input  logic               strobe,
    output logic               txd,
    output logic               busy,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_next;
    logic [15:0]        baud_cnt, baud_cnt_next;
    logic [2:0]         bit_idx, bit_idx_next;
    logic [7:0]         shreg, shreg_next;
    logic               txd_next;

    logic               strobe_d;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               capture, full, pop, push, drop;

    assign capture = strobe & ~strobe_d;
    assign full    = (fifo_count == FULL_COUNT);
    assign pop     = (state == IDLE) && (fifo_count != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;
    assign busy    = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            strobe_d   <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            strobe_d <= strobe;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shreg    <= shreg_next;
            txd      <= txd_next;
        end
    end

    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_idx_next  = bit_idx;
        shreg_next    = shreg;
        txd_next      = txd;
        case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (pop) begin
                    shreg_next    = mem[rd_ptr];
                    baud_cnt_next = BIT_RELOAD;
                    state_next    = START;
                    txd_next      = 1'b0;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    txd_next      = shreg[0];
                    bit_idx_next  = '0;
                    baud_cnt_next = BIT_RELOAD;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt - 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_cnt_next = BIT_RELOAD;
                    if (bit_idx == 3'd7) begin
                        txd_next   = 1'b1;
                        state_next = STOP;
                    end else begin
                        shreg_next   = {1'b0, shreg[7:1]};
                        txd_next     = shreg[1];
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt - 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    baud_cnt_next = baud_cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Downstream consumer of the multi-byte serializer's byte stream (8-bit data plus level "ready" strobe).
- Captures each byte on the strobe's rising edge into a small FIFO.
- Transmits each byte on a single UART line: 8N1, LSB first, in arrival order.
- Decouples the serializer's burst rate from the slow serial line and flags dropped bytes.

Parameters:
- CLKS_PER_BIT, 434, pclk cycles per UART bit. Legal range 2..65535; the baud counter is 16 bits.
- FIFO_AW, 2, FIFO address width. Depth = 2**FIFO_AW entries, default 4.

Ports:
- pclk  input  1  clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  8  byte from upstream serializer.
- strobe  input  1  upstream byte-valid level. A byte is captured only on a 0->1 transition.
- txd  output  1  UART serial out, registered, idle high.
- busy  output  1  high while a frame is in progress or the FIFO is non-empty.
- overflow  output  1  sticky; set when a captured byte is dropped because the FIFO is full.
- fifo_count  output  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW.

Behaviour:
- One clock (pclk). Reset is synchronous and active-high (rst).
- Reset values: txd=1, busy=0, overflow=0, fifo_count=0, state=IDLE, baud counter=0, bit index=0, strobe_d=1.
- strobe_d resets to 1, so a strobe already high when reset releases is ignored.
- Capture: at an edge where strobe=1 and strobe_d=0, din is written to the FIFO tail.
  - strobe_d <= strobe every cycle.
  - A strobe held high for N cycles yields exactly one capture.
- Full FIFO with no pop in the same cycle: the byte is dropped, overflow <= 1, and overflow holds until rst.
- Full FIFO with a pop in the same cycle: the write is accepted, count is unchanged, overflow is not set.
- FIFO is a circular buffer. Read and write pointers wrap modulo depth. fifo_count = writes minus pops, registered.
- TX state machine, four states:
  - IDLE: txd=1. If fifo_count!=0: pop the head into shift register, baud counter <= CLKS_PER_BIT-1, state <= START, txd <= 0.
  - START: txd=0. When the counter reaches 0: txd <= shreg[0], bit index <= 0, reload counter, state <= DATA.
  - DATA: on each counter expiry, shift right and output the next bit. After bit 7 expires: txd <= 1, reload, state <= STOP.
  - STOP: txd=1. On counter expiry, state <= IDLE.
  - The counter decrements every cycle in START, DATA and STOP. Every bit lasts exactly CLKS_PER_BIT cycles.
- Latency: capture at edge E0. At E1 IDLE pops the byte and txd goes low. txd falling edge comes one cycle after the capture edge.
- Back-to-back frames: always exactly one IDLE cycle (txd=1) between a stop bit and the next start bit. Frame period = 10*CLKS_PER_BIT+1 cycles.
- busy = (state!=IDLE) or (fifo_count!=0), combinational from registers.
- Reset mid-operation: at the first edge with rst=1, the frame aborts and txd=1, the FIFO empties, and overflow clears. No partial frame resumes after reset.
- Bytes from a single serializer word are sent in the order received (MSB byte first, as the serializer emits them).

Test Plan:
1. CLKS_PER_BIT=4, rst then one strobe pulse with din=0xA5 -> txd low 1 cycle after the capture edge. Bits are 0 | 1,0,1,0,0,1,0,1 | 1, each 4 cycles. busy falls after 40 cycles in START/DATA/STOP.
2. CLKS_PER_BIT=4, bytes 0x12, 0x34, 0x56 sent with strobe 1 cycle high / 1 cycle low -> fifo_count peaks at 2. Frames appear in order 0x12, 0x34, 0x56, separated by exactly 1 idle cycle. overflow=0.
3. strobe held high 10 cycles with din=0x3C, and strobe high across reset release -> exactly one frame 0x3C for the first case. No frame for the held-through-reset case.
4. FIFO_AW=2, six bytes 0x01..0x06 in quick succession during frame 1 -> 0x01 transmits and 0x02..0x05 are buffered (count=4). 0x06 is dropped and overflow=1 stays set. Exactly five frames are output.
5. rst asserted during data bit 3 with 2 bytes queued -> next cycle txd=1, fifo_count=0, busy=0, overflow=0. No frame follows.
6. FIFO full (4), with a new strobe edge coinciding with the IDLE pop cycle -> write accepted, fifo_count stays 4, overflow=0. All five bytes transmit.
